omsp_atom_irq_gate: RTL and testbench

Sits between the peripheral IRQ lines and the CPU frontend, on the receiving side of the atomicity monitor's `gie` and `atom_violation` outputs. Latches interrupt requests while the monitor masks interrupts. Releases the highest-priority pending interrupt through a req/ack handshake once `gie` is high. Also measures deferral latency and turns atomicity violations into a dedicated, acknowledged violation request.

---
 rtl/omsp_atom_irq_gate_pkg.sv | 33 +++
 rtl/omsp_irq_prio_enc.sv | 37 +++
 rtl/omsp_atom_irq_gate.sv | 203 ++++++++++++++++++++
 tb/tb_omsp_atom_irq_gate.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/omsp_atom_irq_gate_pkg.sv
// -----------------------------------------------------------------------------
// omsp_atom_irq_gate_pkg
//
// Shared definitions for the atomic-section interrupt gate:
//   - gate_state_e : 2-bit FSM encoding (IDLE=0, MASKED=1, REQ=2, VIOL=3).
//                    The encoding is fixed because it is exported on the
//                    fsm_state debug port and decoded by other blocks.
//   - default parameter values for the gate (IRQ count, deferral counter
//     width, deferral timeout bound).
//
// Optional feature macro used by the gate: ATOM_LATENCY_STATS_EN.
// -----------------------------------------------------------------------------
package omsp_atom_irq_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MASKED = 2'd1,
    ST_REQ    = 2'd2,
    ST_VIOL   = 2'd3
  } gate_state_e;

  localparam int NIRQ_DFLT        = 14;
  localparam int DEF_W_DFLT       = 8;
  // Must stay below 2**DEF_W - 1 so the saturating counter can reach it
  // exactly once per deferral.
  localparam int DEFER_BOUND_DFLT = 200;

  // True for states in which the gate presents some request to the frontend.
  function automatic logic is_requesting(input gate_state_e s);
    return (s == ST_REQ) || (s == ST_VIOL);
  endfunction

endpackage

// File: rtl/omsp_irq_prio_enc.sv
// -----------------------------------------------------------------------------
// omsp_irq_prio_enc
//
// Parameterised highest-index priority encoder. Bit N-1 of req has the
// highest priority. Purely combinational; reusable by the CPU frontend.
//
// Parameters:
//   N : number of request inputs (>= 2)
//   W : index width, $clog2(N)
// Ports:
//   req   in  [N-1:0]  request vector
//   idx   out [W-1:0]  index of highest set bit (0 when none set)
//   valid out          at least one bit of req is set
// -----------------------------------------------------------------------------
module omsp_irq_prio_enc #(
  parameter int N = 14,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Ascending scan: the last set bit seen overwrites earlier ones, so the
  // highest index wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/omsp_atom_irq_gate.sv
// -----------------------------------------------------------------------------
// omsp_atom_irq_gate
//
// Sits between the peripheral IRQ lines and the CPU frontend, downstream of
// the atomicity monitor. Latches IRQ requests while interrupts are masked,
// releases the highest-priority pending IRQ through a req/ack handshake once
// gie is high, measures how long the pending set has been deferred, and
// converts atomicity violations into a dedicated violation request.
//
// Handshakes:
//   irq_req/irq_acc   : irq_req is held high with a stable irq_num until the
//                       cycle irq_acc is sampled high; the request drops on the
//                       next edge. If gie falls before acceptance the request
//                       is withdrawn (irq_num held) and re-issued once gie
//                       returns. irq_acc is only meaningful while irq_req=1.
//   viol_req/viol_ack : viol_req stays high until viol_ack is sampled high;
//                       it can never be masked.
//
// Optional feature (macro ATOM_LATENCY_STATS_EN): max_defer records the
// largest deferral seen. Without the macro max_defer is tied to zero.
//
// Ports:
//   mclk            in   system clock
//   puc_rst         in   synchronous active-high reset
//   irq_in          in   [NIRQ-1:0] level IRQ requests (NIRQ-1 = highest prio)
//   gie             in   effective interrupt enable from atomicity monitor
//   atom_violation  in   single-cycle violation flag from atomicity monitor
//   irq_acc         in   frontend accepts the presented IRQ
//   viol_ack        in   frontend accepts the violation request
//   irq_req         out  maskable IRQ request
//   irq_num         out  index of requested IRQ, stable while irq_req=1
//   viol_req        out  violation request
//   defer_cnt       out  cycles the current pending set has been masked
//   defer_timeout   out  one-cycle pulse when defer_cnt reaches DEFER_BOUND
//   max_defer       out  largest deferral observed (stats build only)
//   fsm_state       out  debug: current FSM state
//   pending         out  debug: latched pending IRQ bits
// -----------------------------------------------------------------------------
module omsp_atom_irq_gate
  import omsp_atom_irq_gate_pkg::*;
#(
  parameter int NIRQ        = NIRQ_DFLT,
  parameter int DEF_W       = DEF_W_DFLT,
  parameter int DEFER_BOUND = DEFER_BOUND_DFLT
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic [NIRQ-1:0]         irq_in,
  input  logic                    gie,
  input  logic                    atom_violation,
  input  logic                    irq_acc,
  input  logic                    viol_ack,
  output logic                    irq_req,
  output logic [$clog2(NIRQ)-1:0] irq_num,
  output logic                    viol_req,
  output logic [DEF_W-1:0]        defer_cnt,
  output logic                    defer_timeout,
  output logic [DEF_W-1:0]        max_defer,
  output gate_state_e             fsm_state,
  output logic [NIRQ-1:0]         pending
);

  localparam int               IW    = $clog2(NIRQ);
  localparam logic [DEF_W-1:0] BOUND = DEF_W'(DEFER_BOUND);

  gate_state_e       state_q, state_nxt;
  logic [NIRQ-1:0]   pend_q;
  logic [NIRQ-1:0]   req_vec;
  logic [NIRQ-1:0]   acc_clr;
  logic [IW-1:0]     winner;
  logic              any_req;
  logic [IW-1:0]     num_q;
  logic              load_num;
  logic              accepted;
  logic [DEF_W-1:0]  cnt_q, cnt_nxt;
  logic              tmo_q, tmo_nxt;

  // ---------------------------------------------------------------------------
  // Arbitration: live lines are OR-ed in so a request arriving in IDLE is
  // serviced without first waiting a cycle to be latched.
  // ---------------------------------------------------------------------------
  assign req_vec = pend_q | irq_in;

  omsp_irq_prio_enc #(
    .N (NIRQ),
    .W (IW)
  ) u_prio_enc (
    .req   (req_vec),
    .idx   (winner),
    .valid (any_req)
  );

  // An acceptance coinciding with a violation is not honoured: the violation
  // preempts the transition, so the IRQ must remain pending.
  assign accepted = (state_q == ST_REQ) && irq_acc && !atom_violation;
  assign acc_clr  = accepted ? (NIRQ'(1) << num_q) : '0;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    if (atom_violation) begin
      // Also covers VIOL: a repeated violation is absorbed, and it wins over
      // a simultaneous viol_ack.
      state_nxt = ST_VIOL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) state_nxt = gie ? ST_REQ : ST_MASKED;
        end
        ST_MASKED: begin
          if (gie) state_nxt = ST_REQ;
        end
        ST_REQ: begin
          // Acceptance has priority over a simultaneous gie fall.
          if (irq_acc)   state_nxt = ST_IDLE;
          else if (!gie) state_nxt = ST_MASKED;
        end
        ST_VIOL: begin
          if (viol_ack) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // irq_num is captured only when entering REQ, so it never re-prioritises
  // while a request is outstanding and is held through MASKED.
  assign load_num = (state_nxt == ST_REQ) && (state_q != ST_REQ);

  // ---------------------------------------------------------------------------
  // Deferral counter: counts cycles spent in MASKED, cleared on entry to REQ
  // or IDLE, frozen otherwise (notably across VIOL).
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_nxt = cnt_q;
    if ((state_nxt == ST_REQ) || (state_nxt == ST_IDLE)) begin
      cnt_nxt = '0;
    end else if ((state_q == ST_MASKED) && (state_nxt == ST_MASKED) &&
                 (cnt_q != '1)) begin
      cnt_nxt = cnt_q + DEF_W'(1);
    end
  end

  // Fires only on the transition into BOUND; saturation above BOUND means the
  // counter cannot revisit it within one deferral.
  assign tmo_nxt = (cnt_nxt == BOUND) && (cnt_q != BOUND);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      // Set wins over clear: a line still high re-latches immediately.
      pend_q  <= (pend_q & ~acc_clr) | irq_in;
      if (load_num) num_q <= winner;
      cnt_q   <= cnt_nxt;
      tmo_q   <= tmo_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional latency statistics
  // ---------------------------------------------------------------------------
`ifdef ATOM_LATENCY_STATS_EN
  logic [DEF_W-1:0] max_q;
  logic             masked_exit;

  assign masked_exit = (state_q == ST_MASKED) && (state_nxt != ST_MASKED);

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      max_q <= '0;
    end else if (masked_exit && (cnt_q > max_q)) begin
      max_q <= cnt_q;
    end
  end

  assign max_defer = max_q;
`else
  assign max_defer = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: all decoded directly from registers.
  // ---------------------------------------------------------------------------
  assign irq_req       = is_requesting(state_q) && (state_q == ST_REQ);
  assign viol_req      = (state_q == ST_VIOL);
  assign irq_num       = num_q;
  assign defer_cnt     = cnt_q;
  assign defer_timeout = tmo_q;
  assign fsm_state     = state_q;
  assign pending       = pend_q;

endmodule

// File: tb/tb_omsp_atom_irq_gate.sv
// -----------------------------------------------------------------------------
// tb_omsp_atom_irq_gate
//
// Directed bench for omsp_atom_irq_gate with default parameters
// (NIRQ=14, DEF_W=8, DEFER_BOUND=200). Inputs are driven and outputs sampled
// 1 time unit after each rising edge. Honours ATOM_LATENCY_STATS_EN for the
// expected max_defer value.
// -----------------------------------------------------------------------------
module tb_omsp_atom_irq_gate;
  import omsp_atom_irq_gate_pkg::*;

  localparam int NIRQ  = 14;
  localparam int DEF_W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              mclk = 1'b0;
  logic              puc_rst;
  logic [NIRQ-1:0]   irq_in;
  logic              gie;
  logic              atom_violation;
  logic              irq_acc;
  logic              viol_ack;
  logic              irq_req;
  logic [3:0]        irq_num;
  logic              viol_req;
  logic [DEF_W-1:0]  defer_cnt;
  logic              defer_timeout;
  logic [DEF_W-1:0]  max_defer;
  gate_state_e       fsm_state;
  logic [NIRQ-1:0]   pending;

  always #5 mclk = ~mclk;

  omsp_atom_irq_gate dut (
    .mclk           (mclk),
    .puc_rst        (puc_rst),
    .irq_in         (irq_in),
    .gie            (gie),
    .atom_violation (atom_violation),
    .irq_acc        (irq_acc),
    .viol_ack       (viol_ack),
    .irq_req        (irq_req),
    .irq_num        (irq_num),
    .viol_req       (viol_req),
    .defer_cnt      (defer_cnt),
    .defer_timeout  (defer_timeout),
    .max_defer      (max_defer),
    .fsm_state      (fsm_state),
    .pending        (pending)
  );

  // ---------------------------------------------------------------------------
  // Counters and helpers
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".irq_req"},   32'(irq_req),       32'd0);
    chk({tag, ".irq_num"},   32'(irq_num),       32'd0);
    chk({tag, ".viol_req"},  32'(viol_req),      32'd0);
    chk({tag, ".defer_cnt"}, 32'(defer_cnt),     32'd0);
    chk({tag, ".timeout"},   32'(defer_timeout), 32'd0);
    chk({tag, ".max_defer"}, 32'(max_defer),     32'd0);
    chk({tag, ".state"},     32'(fsm_state),     32'(ST_IDLE));
    chk({tag, ".pending"},   32'(pending),       32'd0);
  endtask

  int          pulses;
  logic [7:0]  pulse_cnt;
  logic [31:0] exp_max;

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    puc_rst        = 1'b1;
    irq_in         = '0;
    gie            = 1'b0;
    atom_violation = 1'b0;
    irq_acc        = 1'b0;
    viol_ack       = 1'b0;
    tick();
    tick();
    chk_reset_values("rst");
    puc_rst = 1'b0;
    tick();
    chk("idle.state", 32'(fsm_state), 32'(ST_IDLE));

    // --- 1: single pulse on irq_in[3] with gie high --------------------------
    gie    = 1'b1;
    irq_in = 14'(1 << 3);
    tick();
    chk("t1.irq_req", 32'(irq_req), 32'd1);
    chk("t1.irq_num", 32'(irq_num), 32'd3);
    chk("t1.pending", 32'(pending), 32'h8);
    irq_in = '0;
    tick();
    tick();
    chk("t1.hold_req", 32'(irq_req), 32'd1);
    chk("t1.hold_num", 32'(irq_num), 32'd3);
    // Acceptance together with a gie fall: acceptance wins.
    irq_acc = 1'b1;
    gie     = 1'b0;
    tick();
    irq_acc = 1'b0;
    chk("t1.acc_req",   32'(irq_req),   32'd0);
    chk("t1.acc_pend",  32'(pending),   32'd0);
    chk("t1.acc_state", 32'(fsm_state), 32'(ST_IDLE));
    gie = 1'b1;
    tick();
    chk("t1.quiet", 32'(irq_req), 32'd0);

    // --- 2: masked lines 2 and 9 for 50 cycles -------------------------------
    gie    = 1'b0;
    irq_in = 14'((1 << 2) | (1 << 9));
    tick();
    chk("t2.state", 32'(fsm_state), 32'(ST_MASKED));
    for (int i = 0; i < 50; i++) tick();
    chk("t2.defer50", 32'(defer_cnt), 32'd50);
    chk("t2.no_req",  32'(irq_req),   32'd0);
    gie    = 1'b1;
    irq_in = '0;
    tick();
    chk("t2.req",     32'(irq_req),   32'd1);
    chk("t2.num9",    32'(irq_num),   32'd9);
    chk("t2.cnt_clr", 32'(defer_cnt), 32'd0);
    chk("t2.pend",    32'(pending),   32'h204);
    irq_acc = 1'b1;
    tick();
    irq_acc = 1'b0;
    chk("t2.gap_req", 32'(irq_req), 32'd0);
    chk("t2.pend2",   32'(pending), 32'h004);
    tick();
    chk("t2.req2", 32'(irq_req), 32'd1);
    chk("t2.num2", 32'(irq_num), 32'd2);
    irq_acc = 1'b1;
    tick();
    irq_acc = 1'b0;

    // --- 3: gie drop during REQ, re-issue, no re-prioritisation --------------
    irq_in = 14'(1 << 5);
    tick();
    chk("t3.num5", 32'(irq_num), 32'd5);
    irq_in = '0;
    gie    = 1'b0;
    tick();
    chk("t3.withdrawn", 32'(irq_req),   32'd0);
    chk("t3.masked",    32'(fsm_state), 32'(ST_MASKED));
    chk("t3.num_held",  32'(irq_num),   32'd5);
    tick();
    tick();
    tick();
    chk("t3.defer3", 32'(defer_cnt), 32'd3);
    gie = 1'b1;
    tick();
    chk("t3.reissue", 32'(irq_req), 32'd1);
    chk("t3.num5b",   32'(irq_num), 32'd5);
    irq_in = 14'(1 << 7);
    tick();
    irq_in = '0;
    chk("t3.no_reprio", 32'(irq_num), 32'd5);
    irq_acc = 1'b1;
    tick();
    irq_acc = 1'b0;
    chk("t3.pend7", 32'(pending), 32'h80);
    tick();
    chk("t3.num7", 32'(irq_num), 32'd7);
    irq_acc = 1'b1;
    tick();
    irq_acc = 1'b0;

    // --- 4: deferral timeout -------------------------------------------------
    gie    = 1'b0;
    irq_in = 14'(1 << 1);
    tick();
    irq_in = '0;
    chk("t4.masked", 32'(fsm_state), 32'(ST_MASKED));
    pulses    = 0;
    pulse_cnt = '0;
    for (int i = 0; i < 210; i++) begin
      tick();
      if (defer_timeout) begin
        pulses++;
        pulse_cnt = defer_cnt;
      end
    end
    chk("t4.pulses",    32'(pulses),    32'd1);
    chk("t4.pulse_at",  32'(pulse_cnt), 32'd200);
    chk("t4.defer210",  32'(defer_cnt), 32'd210);
    gie = 1'b1;
    tick();
`ifdef ATOM_LATENCY_STATS_EN
    exp_max = 32'd210;
`else
    exp_max = 32'd0;
`endif
    chk("t4.max_defer", 32'(max_defer), exp_max);
    chk("t4.num1",      32'(irq_num),   32'd1);
    chk("t4.cnt_clr",   32'(defer_cnt), 32'd0);

    // --- 5: violation during REQ ---------------------------------------------
    atom_violation = 1'b1;
    tick();
    atom_violation = 1'b0;
    chk("t5.irq_req",  32'(irq_req),  32'd0);
    chk("t5.viol_req", 32'(viol_req), 32'd1);
    chk("t5.pending",  32'(pending),  32'h2);
    tick();
    atom_violation = 1'b1;
    tick();
    atom_violation = 1'b0;
    chk("t5.absorbed", 32'(fsm_state), 32'(ST_VIOL));
    viol_ack       = 1'b1;
    atom_violation = 1'b1;
    tick();
    atom_violation = 1'b0;
    chk("t5.ack_vs_viol", 32'(viol_req), 32'd1);
    tick();
    viol_ack = 1'b0;
    chk("t5.released", 32'(viol_req),  32'd0);
    chk("t5.idle",     32'(fsm_state), 32'(ST_IDLE));
    chk("t5.no_req",   32'(irq_req),   32'd0);
    tick();
    chk("t5.rereq", 32'(irq_req), 32'd1);
    chk("t5.num1",  32'(irq_num), 32'd1);
    irq_acc = 1'b1;
    tick();
    irq_acc = 1'b0;

    // --- 6: reset during VIOL with pending bits ------------------------------
    gie    = 1'b0;
    irq_in = 14'(1 << 12);
    tick();
    irq_in = '0;
    for (int i = 0; i < 5; i++) tick();
    chk("t6.defer5", 32'(defer_cnt), 32'd5);
    atom_violation = 1'b1;
    tick();
    atom_violation = 1'b0;
    chk("t6.viol",      32'(viol_req),  32'd1);
    chk("t6.cnt_hold",  32'(defer_cnt), 32'd5);
    chk("t6.pend",      32'(pending),   32'h1000);
    puc_rst = 1'b1;
    tick();
    chk_reset_values("t6.rst");
    puc_rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
